// File: rtl/cb_douta_router_pkg.sv
// Select-field encodings shared between the CB read-data router and the sequencer
// that drives CB_douta_sel = {dst, dir}.
package cb_douta_router_pkg;

  localparam int unsigned DST_IDLE = 0;
  localparam int unsigned DST_A    = 1;
  localparam int unsigned DST_B    = 2;
  localparam int unsigned DST_M    = 3;
  localparam int unsigned DST_TB   = 4;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2,
    DIR_PAIR = 2'd3
  } dir_e;

endpackage

// File: rtl/cb_douta_router_seq_dly.sv
// seq_cnt delay line: DEPTH-stage shift register with clock enable and
// synchronous active-low clear, aligning seq_cnt with the CB read latency.
module cb_seq_dly #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_sr[k] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int unsigned k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/cb_douta_router.sv
// Routes CB port-A read lanes to the A/B/M operand buses and the TB write-data bus,
// with per-destination valids, stall and a seq_cnt delay line for TB placement.
module cb_douta_router
  import cb_douta_router_pkg::*;
#(
  parameter int unsigned X          = 4,
  parameter int unsigned Y          = 4,
  parameter int unsigned L          = 4,
  parameter int unsigned RSA_DW     = 32,
  parameter int unsigned SEQ_CNT_DW = 10,
  parameter int unsigned SEL_DW     = 5,
  parameter int unsigned SEQ_DLY    = 2
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  stall,
  input  logic [SEL_DW-1:0]     CB_douta_sel,
  input  logic [SEQ_CNT_DW-1:0] l_k,
  input  logic [SEQ_CNT_DW-1:0] seq_cnt_out,
  input  logic                  in_valid,
  input  logic [L*RSA_DW-1:0]   CB_douta,
  output logic [X*RSA_DW-1:0]   A_CB_douta,
  output logic [Y*RSA_DW-1:0]   B_CB_douta,
  output logic [X*RSA_DW-1:0]   M_CB_douta,
  output logic [X*RSA_DW-1:0]   TB_dina_CB_douta,
  output logic                  A_vld,
  output logic                  B_vld,
  output logic                  M_vld,
  output logic                  TB_vld
);

  localparam int unsigned DST_W = SEL_DW - 2;
  localparam int unsigned PW    = $clog2(L / 2);
  localparam int unsigned KX    = (X < L) ? X : L;
  localparam int unsigned KY    = (Y < L) ? Y : L;
  localparam logic [DST_W-1:0]      C_DST_A  = DST_W'(DST_A);
  localparam logic [DST_W-1:0]      C_DST_B  = DST_W'(DST_B);
  localparam logic [DST_W-1:0]      C_DST_M  = DST_W'(DST_M);
  localparam logic [DST_W-1:0]      C_DST_TB = DST_W'(DST_TB);
  localparam logic [SEQ_CNT_DW-1:0] C_X      = SEQ_CNT_DW'(X);

  logic [DST_W-1:0]      w_dst;
  dir_e                  w_dir;
  logic [PW-1:0]         w_p;
  logic [SEQ_CNT_DW-1:0] w_s;
  logic                  w_unused;
  logic [RSA_DW-1:0]     w_in [L];
  logic [RSA_DW-1:0]     w_lo, w_hi;

  logic [X-1:0][RSA_DW-1:0] w_pos_x, w_neg_x, w_pair_x, w_tb_x, w_map_x;
  logic [Y-1:0][RSA_DW-1:0] w_pos_y, w_neg_y, w_pair_y, w_map_y;
  logic [X-1:0][RSA_DW-1:0] w_a_nxt, w_m_nxt, w_tb_nxt;
  logic [Y-1:0][RSA_DW-1:0] w_b_nxt;
  logic w_a_vld_nxt, w_b_vld_nxt, w_m_vld_nxt, w_tb_vld_nxt;

  assign w_dst    = CB_douta_sel[SEL_DW-1:2];
  assign w_dir    = dir_e'(CB_douta_sel[1:0]);
  assign w_p      = ~l_k[PW-1:0];
  assign w_unused = ^l_k[SEQ_CNT_DW-1:PW];

  cb_seq_dly #(
    .DW    (SEQ_CNT_DW),
    .DEPTH (SEQ_DLY)
  ) u_seq_dly (
    .i_clk   (clk),
    .i_rst_n (sys_rst_n),
    .i_en    (~stall),
    .i_d     (seq_cnt_out),
    .o_q     (w_s)
  );

  for (genvar gi = 0; gi < L; gi++) begin : g_unpack
    assign w_in[gi] = CB_douta[gi*RSA_DW +: RSA_DW];
  end

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int unsigned j = 0; j < L / 2; j++) begin
      if (w_p == PW'(j)) begin
        w_lo = w_in[2*j];
        w_hi = w_in[2*j+1];
      end
    end
  end

  for (genvar gx = 0; gx < X; gx++) begin : g_x
    localparam logic [SEQ_CNT_DW-1:0] C_LO_S = SEQ_CNT_DW'(gx + 1);
    localparam logic [SEQ_CNT_DW-1:0] C_HI_S = SEQ_CNT_DW'(gx + 2);
    localparam bit                    C_LAST = (gx == X - 1);
    if (gx < KX) begin : g_in
      assign w_pos_x[gx] = w_in[gx];
      assign w_neg_x[gx] = w_in[L-1-gx];
    end else begin : g_zero
      assign w_pos_x[gx] = '0;
      assign w_neg_x[gx] = '0;
    end
    assign w_pair_x[gx] = (gx == 0) ? w_lo : (gx == 1) ? w_hi : '0;
    // s=0 parks hi in the top lane; s in 1..X places lo at s-1 and hi just below it.
    assign w_tb_x[gx] = (w_s == C_LO_S) ? w_lo :
                        (((w_s == C_HI_S) && (w_s <= C_X)) || (C_LAST && (w_s == '0))) ? w_hi :
                        '0;
  end

  for (genvar gy = 0; gy < Y; gy++) begin : g_y
    if (gy < KY) begin : g_in
      assign w_pos_y[gy] = w_in[gy];
      assign w_neg_y[gy] = w_in[L-1-gy];
    end else begin : g_zero
      assign w_pos_y[gy] = '0;
      assign w_neg_y[gy] = '0;
    end
    assign w_pair_y[gy] = (gy == 0) ? w_lo : (gy == 1) ? w_hi : '0;
  end

  always_comb begin
    w_map_x = '0;
    w_map_y = '0;
    case (w_dir)
      DIR_POS:  begin w_map_x = w_pos_x;  w_map_y = w_pos_y;  end
      DIR_NEG:  begin w_map_x = w_neg_x;  w_map_y = w_neg_y;  end
      DIR_PAIR: begin w_map_x = w_pair_x; w_map_y = w_pair_y; end
      default:  begin w_map_x = '0;       w_map_y = '0;       end
    endcase
  end

  always_comb begin
    w_a_nxt      = '0;
    w_b_nxt      = '0;
    w_m_nxt      = '0;
    w_tb_nxt     = '0;
    w_a_vld_nxt  = 1'b0;
    w_b_vld_nxt  = 1'b0;
    w_m_vld_nxt  = 1'b0;
    w_tb_vld_nxt = 1'b0;
    if (w_dst == C_DST_A) begin
      w_a_nxt     = w_map_x;
      w_a_vld_nxt = in_valid;
    end else if (w_dst == C_DST_B) begin
      w_b_nxt     = w_map_y;
      w_b_vld_nxt = in_valid;
    end else if (w_dst == C_DST_M) begin
      w_m_nxt     = w_map_x;
      w_m_vld_nxt = in_valid;
    end else if ((w_dst == C_DST_TB) && (w_dir == DIR_PAIR) && (w_s <= C_X)) begin
      w_tb_nxt     = w_tb_x;
      w_tb_vld_nxt = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      A_CB_douta       <= '0;
      B_CB_douta       <= '0;
      M_CB_douta       <= '0;
      TB_dina_CB_douta <= '0;
      A_vld            <= 1'b0;
      B_vld            <= 1'b0;
      M_vld            <= 1'b0;
      TB_vld           <= 1'b0;
    end else if (!stall) begin
      A_CB_douta       <= w_a_nxt;
      B_CB_douta       <= w_b_nxt;
      M_CB_douta       <= w_m_nxt;
      TB_dina_CB_douta <= w_tb_nxt;
      A_vld            <= w_a_vld_nxt;
      B_vld            <= w_b_vld_nxt;
      M_vld            <= w_m_vld_nxt;
      TB_vld           <= w_tb_vld_nxt;
    end
  end

endmodule

// File: tb/tb_cb_douta_router.sv
// Directed bench for cb_douta_router: a 4-lane instance plus an 8-lane instance
// sharing control inputs, checked against hand-computed lane vectors.
module tb_cb_douta_router;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic [4:0]   sel;
  logic [9:0]   l_k;
  logic [9:0]   seq;
  logic         in_valid;
  logic [127:0] din;
  logic [255:0] din8;

  logic [127:0] a4, b4, m4, tb4;
  logic         av4, bv4, mv4, tv4;
  logic [127:0] a8, b8, m8, tb8;
  logic         av8, bv8, mv8, tv8;

  int n_chk;
  int n_bad;

  logic [127:0] exp_tb  [6];
  logic         exp_tbv [6];

  cb_douta_router #(.X(4), .Y(4), .L(4), .RSA_DW(32), .SEQ_CNT_DW(10), .SEL_DW(5), .SEQ_DLY(2)) u_dut (
    .clk(clk), .sys_rst_n(rst_n), .stall(stall), .CB_douta_sel(sel), .l_k(l_k),
    .seq_cnt_out(seq), .in_valid(in_valid), .CB_douta(din),
    .A_CB_douta(a4), .B_CB_douta(b4), .M_CB_douta(m4), .TB_dina_CB_douta(tb4),
    .A_vld(av4), .B_vld(bv4), .M_vld(mv4), .TB_vld(tv4)
  );

  cb_douta_router #(.X(4), .Y(4), .L(8), .RSA_DW(32), .SEQ_CNT_DW(10), .SEL_DW(5), .SEQ_DLY(2)) u_dut8 (
    .clk(clk), .sys_rst_n(rst_n), .stall(stall), .CB_douta_sel(sel), .l_k(l_k),
    .seq_cnt_out(seq), .in_valid(in_valid), .CB_douta(din8),
    .A_CB_douta(a8), .B_CB_douta(b8), .M_CB_douta(m8), .TB_dina_CB_douta(tb8),
    .A_vld(av8), .B_vld(bv8), .M_vld(mv8), .TB_vld(tv8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ln(input int a3, input int a2, input int a1, input int a0);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [4:0] mk_sel(input int dst, input int dir);
    return {3'(dst), 2'(dir)};
  endfunction

  initial begin
    n_chk = 0;
    n_bad = 0;
    exp_tb[0] = ln(2, 0, 0, 0); exp_tbv[0] = 1'b1;
    exp_tb[1] = ln(0, 0, 0, 1); exp_tbv[1] = 1'b1;
    exp_tb[2] = ln(0, 0, 1, 2); exp_tbv[2] = 1'b1;
    exp_tb[3] = ln(0, 1, 2, 0); exp_tbv[3] = 1'b1;
    exp_tb[4] = ln(1, 2, 0, 0); exp_tbv[4] = 1'b1;
    exp_tb[5] = '0;             exp_tbv[5] = 1'b0;

    rst_n    = 1'b0;
    stall    = 1'b0;
    sel      = '0;
    l_k      = '0;
    seq      = 10'd9;
    in_valid = 1'b0;
    din      = ln(4, 3, 2, 1);
    din8     = {ln(8, 7, 6, 5), ln(4, 3, 2, 1)};
    step();
    step();
    rst_n = 1'b1;

    // A | POS
    sel = mk_sel(1, 1); in_valid = 1'b1;
    step();
    chk("a_pos",      a4, ln(4, 3, 2, 1));
    chk("a_pos_vld",  {124'd0, av4, bv4, mv4, tv4}, 128'b1000);
    chk("a_pos_b",    b4, '0);
    chk("a_pos_m",    m4, '0);
    chk("a_pos_tb",   tb4, '0);
    chk("a8_pos",     a8, ln(4, 3, 2, 1));

    // B | NEG
    sel = mk_sel(2, 2);
    step();
    chk("b_neg",      b4, ln(1, 2, 3, 4));
    chk("b_neg_a",    a4, '0);
    chk("b_neg_vld",  {124'd0, av4, bv4, mv4, tv4}, 128'b0100);
    chk("b8_neg",     b8, ln(5, 6, 7, 8));

    // M | PAIR
    sel = mk_sel(3, 3); l_k = 10'd1;
    step();
    chk("m_pair_lk1",  m4, ln(0, 0, 2, 1));
    chk("m_pair_vld",  {124'd0, av4, bv4, mv4, tv4}, 128'b0010);
    chk("m8_pair_lk1", m8, ln(0, 0, 6, 5));
    l_k = 10'd0;
    step();
    chk("m_pair_lk0",  m4, ln(0, 0, 4, 3));
    chk("m8_pair_lk0", m8, ln(0, 0, 8, 7));
    l_k = 10'd2;
    step();
    chk("m8_pair_lk2", m8, ln(0, 0, 4, 3));

    // reset wins over stall with non-zero inputs
    rst_n = 1'b0; stall = 1'b1; sel = mk_sel(1, 1); in_valid = 1'b1;
    step();
    chk("rst_a",   a4, '0);
    chk("rst_m",   m4, '0);
    chk("rst_m8",  m8, '0);
    chk("rst_vld", {124'd0, av4, bv4, mv4, tv4}, '0);
    rst_n = 1'b1; stall = 1'b0;

    // TB | PAIR sweep; second pass inserts a 3-cycle stall after s=2
    sel = mk_sel(4, 3); l_k = 10'd1; in_valid = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) begin
        seq = 10'(k);
        step();
        if (k >= 2) begin
          chk($sformatf("tb_p%0d_s%0d", pass, k - 2), tb4, exp_tb[k-2]);
          chk($sformatf("tbv_p%0d_s%0d", pass, k - 2), {127'd0, tv4}, {127'd0, exp_tbv[k-2]});
        end
        if (pass == 1 && k == 4) begin
          stall = 1'b1; seq = 10'd5; l_k = 10'd0; din = ln(9, 9, 9, 9);
          for (int h = 0; h < 3; h++) begin
            step();
            chk($sformatf("stall_tb_%0d", h), tb4, exp_tb[2]);
            chk($sformatf("stall_tbv_%0d", h), {127'd0, tv4}, 128'd1);
          end
          stall = 1'b0; l_k = 10'd1; din = ln(4, 3, 2, 1);
        end
      end
    end

    // TB with a non-PAIR dir stays silent
    sel = mk_sel(4, 1); seq = 10'd1;
    step();
    step();
    chk("tb_pos",     tb4, '0);
    chk("tb_pos_vld", {127'd0, tv4}, '0);

    // reserved dst
    sel = mk_sel(6, 1); in_valid = 1'b1;
    step();
    chk("rsv_a",   a4, '0);
    chk("rsv_b",   b4, '0);
    chk("rsv_m",   m4, '0);
    chk("rsv_vld", {124'd0, av4, bv4, mv4, tv4}, '0);

    // selected vld follows in_valid one cycle later
    sel = mk_sel(1, 1);
    for (int t = 0; t < 4; t++) begin
      in_valid = (t % 2 == 0) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("vld_track_%0d", t), {127'd0, av4}, {127'd0, (t % 2 == 0)});
      chk($sformatf("vld_track_a_%0d", t), a4, ln(4, 3, 2, 1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
